// File: rtl/line_burst_adapter.sv
// Purpose : moves whole 256-bit cache lines to/from a 64-bit burst memory port
//           (fill = gather 4 beats into a line, writeback = serialize a line as 4 beats).
// Latency : accept -> 4 beats -> one-cycle resp_o -> IDLE (5 edges minimum);
//           with LINE_ADAPTER_FWD_EN a fill reports resp_o in its last-beat cycle.
// Backpressure: memory paces beats with resp_i (unbounded stalls); new requests are
//           only sampled in IDLE, so the cache must hold read_i/write_i until accepted.
//
// Optional feature macro: LINE_ADAPTER_FWD_EN (fill forwarding of the final beat).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   read_i, write_i   fill / writeback request from the cache (write wins on a tie)
//   address_i         line address, latched on accept
//   line_i            writeback line, latched on accept of write_i
//   line_o, resp_o    assembled/held line and one-cycle completion pulse
//   read_o, write_o   burst read / burst write request to memory
//   address_o         latched address, line aligned (bits [4:0] zero)
//   burst_o           current writeback beat
//   burst_i, resp_i   incoming fill beat and per-beat handshake from memory
module line_burst_adapter #(
  parameter int width       = 256,
  parameter int burst_width = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [31:0]            address_i,
  input  logic [width-1:0]       line_i,
  output logic [width-1:0]       line_o,
  output logic                   resp_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [31:0]            address_o,
  output logic [burst_width-1:0] burst_o,
  input  logic [burst_width-1:0] burst_i,
  input  logic                   resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         cnt;       // beat position; a line is exactly four beats
  logic [width-1:0]   buffer;    // line being gathered (fill) or drained (writeback)
  logic [31:0]        address;
  logic               last_beat; // memory is handing over beat 3 this cycle

  assign last_beat = resp_i && (cnt == 2'd3);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (write_i)     state_nxt = WRITE;
        else if (read_i) state_nxt = READ;
      end
      READ: begin
`ifdef LINE_ADAPTER_FWD_EN
        // Completion is reported in the last-beat cycle, so DONE is skipped.
        if (last_beat) state_nxt = IDLE;
`else
        if (last_beat) state_nxt = DONE;
`endif
      end
      WRITE: begin
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    read_o  = (state == READ);
    write_o = (state == WRITE);
    resp_o  = (state == DONE);
    line_o  = buffer;
    burst_o = '0;
    if (state == WRITE) begin
      burst_o = buffer[cnt*burst_width +: burst_width];
    end
`ifdef LINE_ADAPTER_FWD_EN
    // Forward the final beat straight from the memory port; the lower three
    // beats are already in the buffer.
    if ((state == READ) && last_beat) begin
      resp_o = 1'b1;
      line_o = {burst_i, buffer[width-burst_width-1:0]};
    end
`endif
  end

  assign address_o = {address[31:5], 5'b0_0000};

  // ---------------------------------------------------------------------------
  // State, beat counter, line buffer, address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      buffer  <= '0;
      address <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (write_i) begin
            buffer  <= line_i;
            address <= address_i;
            cnt     <= 2'd0;
          end else if (read_i) begin
            address <= address_i;
            cnt     <= 2'd0;
          end
        end
        READ: begin
          if (resp_i) begin
            buffer[cnt*burst_width +: burst_width] <= burst_i;
            cnt <= cnt + 2'd1;
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: directed fills/writebacks drive the DUT,
// expected completion lines go into a queue, and a negedge monitor pops and compares
// them whenever resp_o is seen.
module tb_line_burst_adapter;

  localparam int W  = 256;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_i;
  logic          write_i;
  logic [31:0]   address_i;
  logic [W-1:0]  line_i;
  logic [W-1:0]  line_o;
  logic          resp_o;
  logic          read_o;
  logic          write_o;
  logic [31:0]   address_o;
  logic [BW-1:0] burst_o;
  logic [BW-1:0] burst_i;
  logic          resp_i;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  line_burst_adapter #(.width(W), .burst_width(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .address_o (address_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every resp_o cycle must match the oldest outstanding expected line.
  always @(negedge clk) begin
    if (!rst && resp_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=1 required=0 line_o=%h", line_o);
      end else begin
        check("resp_line", line_o, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the monitor to consume all outstanding responses.
  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step();
      n++;
    end
    check("resp_seen", exp_q.size(), 0);
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [W-1:0] line, input int stall);
    read_i    = 1'b1;
    address_i = addr;
    exp_q.push_back(line);
    step();
    read_i    = 1'b0;
    address_i = '0;
    check("fill_read_o", read_o, 1);
    check("fill_addr", address_o, {addr[31:5], 5'b0_0000});
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < stall; s++) begin
        check("fill_read_hold", read_o, 1);
        step();
      end
      burst_i = line[k*BW +: BW];
      resp_i  = 1'b1;
      step();
      resp_i  = 1'b0;
      burst_i = '0;
    end
    check("fill_read_drop", read_o, 0);
`ifdef LINE_ADAPTER_FWD_EN
    check("fill_resp_after_fwd", resp_o, 0);
`else
    check("fill_resp_latency", resp_o, 1);
`endif
    wait_drain();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [W-1:0] line,
                          input int stall, input logic also_read);
    write_i   = 1'b1;
    read_i    = also_read;
    address_i = addr;
    line_i    = line;
    exp_q.push_back(line);
    step();
    write_i   = 1'b0;
    read_i    = 1'b0;
    line_i    = '0;
    address_i = '0;
    check("wb_addr", address_o, {addr[31:5], 5'b0_0000});
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < stall; s++) begin
        check("wb_write_hold", write_o, 1);
        check("wb_burst_hold", burst_o, line[k*BW +: BW]);
        read_i = ~read_i;   // must be ignored outside IDLE
        step();
      end
      read_i = 1'b0;
      check("wb_burst", burst_o, line[k*BW +: BW]);
      check("wb_no_read", read_o, 0);
      resp_i = 1'b1;
      step();
      resp_i = 1'b0;
    end
    check("wb_write_drop", write_o, 0);
    check("wb_resp_latency", resp_o, 1);
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] fill_line;
    logic [W-1:0] wb_line;
    logic [W-1:0] tie_line;
    logic [W-1:0] fresh_line;

    fill_line  = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    wb_line    = {64'hFEED_FACE_CAFE_0003, 64'h0BAD_F00D_1234_0002,
                  64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF};
    tie_line   = {64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                  64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF};
    fresh_line = {64'h8888_7777_6666_5555, 64'h1111_2222_3333_4444,
                  64'h0F0F_0F0F_F0F0_F0F0, 64'h9999_AAAA_BBBB_CCCC};

    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0;
    line_i = '0; burst_i = '0; resp_i = 1'b0;

    // Reset values
    #2;
    check("rst_read_o", read_o, 0);
    check("rst_write_o", write_o, 0);
    check("rst_resp_o", resp_o, 0);
    check("rst_address_o", address_o, 0);
    check("rst_burst_o", burst_o, 0);
    check("rst_line_o", line_o, 0);
    #10 rst = 1'b0;
    step();

    // Fill, back-to-back beats
    do_fill(32'h0000_1234, fill_line, 0);

    // Writeback with two stall cycles before every beat, read_i toggled meanwhile
    do_write(32'h8000_00FF, wb_line, 2, 1'b0);

    // Simultaneous read/write request: write wins, read dropped
    do_write(32'h0000_0040, tie_line, 0, 1'b1);
    check("tie_no_read_after", read_o, 0);

    // resp_i in IDLE must be ignored
    burst_i = '1;
    resp_i  = 1'b1;
    step();
    step();
    resp_i  = 1'b0;
    burst_i = '0;
    check("idle_resp_read_o", read_o, 0);
    check("idle_resp_write_o", write_o, 0);
    check("idle_resp_resp_o", resp_o, 0);
    check("idle_line_hold", line_o, tie_line);

    // Reset mid-fill after two beats
    read_i    = 1'b1;
    address_i = 32'h0000_2000;
    step();
    read_i    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      burst_i = {16{4'hE}};
      resp_i  = 1'b1;
      step();
    end
    resp_i  = 1'b0;
    burst_i = '0;
    #3 rst = 1'b1;
    #1;
    check("midrst_read_o", read_o, 0);
    check("midrst_resp_o", resp_o, 0);
    check("midrst_line_o", line_o, 0);
    check("midrst_address_o", address_o, 0);
    #3 rst = 1'b0;
    step();

    // Fresh fill after the abort, with one stall cycle per beat
    do_fill(32'hABCD_EF5F, fresh_line, 1);

    step();
    step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_burst_adapter.md
# line_burst_adapter

Transfers full 256-bit cache lines between a line-wide storage array and a 64-bit burst memory port. On a fill, it collects four 64-bit beats into one line and hands the line to the cache so it can be written into the data array. On a writeback, it latches a line read out of the array and serializes it as four beats. It sits between the cache datapath/controller and the physical memory (or arbiter) port, one instance per cache.

## Interface
Parameters:
- `width`, 256: line width in bits.
- `burst_width`, 64: beat width in bits. `width` must equal 4 × `burst_width`.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `read_i` in 1: cache requests a line fill; sampled only in IDLE.
- `write_i` in 1: cache requests a line writeback; sampled only in IDLE.
- `address_i` in 32: line address; latched on accept.
- `line_i` in width: writeback line; latched on accept of `write_i`.
- `line_o` out width: assembled fill line; valid while `resp_o` is high.
- `resp_o` out 1: one-cycle completion pulse for either operation.
- `read_o` out 1: burst read request to memory.
- `write_o` out 1: burst write request to memory.
- `address_o` out 32: latched address with bits [4:0] forced to 0.
- `burst_o` out burst_width: current writeback beat.
- `burst_i` in burst_width: incoming fill beat; valid when `resp_i` is high.
- `resp_i` in 1: memory beat handshake; each high cycle is one beat.

## Operation
- States:
  - IDLE
  - READ
  - WRITE
  - DONE
- A 2-bit beat counter `cnt` tracks beat position. It is cleared on every request accept.
- IDLE:
  - `write_i` high → latch `line_i` and `address_i`, go to WRITE.
  - Else `read_i` high → latch `address_i`, go to READ.
  - If both are high, write wins; the read is not remembered.
- READ:
  - `read_o` is high.
  - On each edge with `resp_i` high, `buffer[cnt*64 +: 64] <= burst_i` and `cnt++`.
  - When the beat with `cnt==3` is accepted, go to DONE.
- WRITE:
  - `write_o` is high and `burst_o = buffer[cnt*64 +: 64]`.
  - On each edge with `resp_i` high, `cnt++`.
  - When the beat with `cnt==3` is accepted, go to DONE.
- DONE:
  - `resp_o` is high for exactly one cycle and `line_o = buffer`.
  - The next state is always IDLE.
- `read_i`, `write_i`, `address_i` and `line_i` are ignored outside IDLE.
- `resp_i` is ignored in IDLE and DONE.
- Beat 0 maps to bits [63:0]; beat 3 maps to bits [255:192]. The order is little-endian, with no critical-word-first.
- `address_o` holds the latched address through DONE and until the next accept.
- `line_o` holds the buffer contents at all times. A writeback leaves `line_o` equal to the written line.

## Timing
- Reset values:
  - state = IDLE
  - `cnt` = 0
  - buffer = 0
  - address = 0
  - outputs: `resp_o`=0, `read_o`=0, `write_o`=0, `address_o`=0, `burst_o`=0, `line_o`=0
- Accept edge E0: `read_o`/`write_o` go high in the cycle after E0.
- Beats: one beat per `resp_i`-high edge. Stall cycles (`resp_i` low) are allowed between beats without limit.
- Minimum latency: beats on E1–E4, `resp_o` high between E4 and E5, and IDLE at E5. That is 5 edges from accept to IDLE.
- Back-to-back: a request held high during DONE is not accepted until the IDLE cycle. The minimum request spacing is 6 edges.
- `read_o`/`write_o` drop in the cycle after the last beat is accepted.
- Reset mid-burst: asserting `rst` aborts immediately to IDLE with all reset values. No `resp_o` is issued and the partial buffer is discarded.

## Configuration
- `LINE_ADAPTER_FWD_EN` defined:
  - Fill forwarding is enabled. In READ, when `cnt==3` and `resp_i` is high, `resp_o` is driven high combinationally in that same cycle.
  - In that cycle, `line_o = {burst_i, buffer[191:0]}`. The next state is IDLE, skipping DONE.
  - Fill latency drops by one cycle. Writebacks are unchanged.
- `LINE_ADAPTER_FWD_EN` undefined: behaviour is exactly as described in Operation and Timing.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately, state IDLE.
- **Fill:** `read_i`, `address_i`=0x0000_1234, then beats 0x11…11, 0x22…22, 0x33…33, 0x44…44 on consecutive edges.
  - `address_o`=0x0000_1220.
  - `resp_o` pulses one cycle with `line_o`={0x44…44, 0x33…33, 0x22…22, 0x11…11}.
  - `resp_o` rises after E4, or in the E4 cycle under `LINE_ADAPTER_FWD_EN`.
- **Writeback with stalls:** `write_i`, `line_i`={D3,D2,D1,D0}, with `resp_i` low 2 cycles between each beat.
  - `burst_o` presents D0, D1, D2, D3, each held until its beat is accepted.
  - `write_o` stays high throughout; a single `resp_o` follows.
- **Simultaneous request:** `read_i`=`write_i`=1 in IDLE → WRITE is taken, `read_o` is never asserted, one `resp_o`.
- **Ignored inputs:** toggle `read_i` during WRITE and pulse `resp_i` in IDLE → no state change, no extra beats, no `resp_o`.
- **Reset mid-fill:** assert `rst` after 2 beats → return to IDLE, `line_o`=0, no `resp_o`. A fresh fill afterwards completes correctly.
